nano_uart_loader: RTL and testbench
===================================

// Module: nano_uart_loader
// PURPOSE
// - Serial boot loader directly upstream of nano_top: receives a program image over UART RX and writes
//   it word-by-word into the nano core's program RAM.
// - Holds the core in reset (cpu_hold) until the image is complete, then releases it; the core then runs.
// PARAMETERS
// - CLKS_PER_BIT  434  clocks per UART bit (50 MHz / 115200); minimum legal value 4
// - ADDR_W        10   program RAM address width
// - DATA_W        16   program word width; must be a multiple of 8, little-endian byte order
// PORTS
// - clock       in   1       system clock, all logic on posedge
// - sreset      in   1       synchronous active-high reset
// - rx          in   1       UART receive line, idle high, 8N1, asynchronous to clock
// - prog_we     out  1       one-cycle program RAM write strobe
// - prog_addr   out  ADDR_W  write address, valid when prog_we=1
// - prog_data   out  DATA_W  write data, valid when prog_we=1
// - cpu_hold    out  1       drives nano core reset; 1 while loading or in error
// - load_done   out  1       sticky: image fully received and accepted
// - load_err    out  1       sticky: framing, length or checksum error
// BEHAVIOUR
// - Reset values: prog_we=0, prog_addr=0, prog_data=0, cpu_hold=1, load_done=0, load_err=0.
// - rx passes through a 2-flop synchroniser, reset to 1; all decoding uses the synchronised value.
// - UART RX FSM: IDLE -> START on synchronised falling edge.
//   - START: sample at CLKS_PER_BIT/2; if rx=1, return to IDLE as a glitch with no error.
//   - DATA: 8 bits, LSB first, each sampled at mid-bit (every CLKS_PER_BIT clocks).
//   - STOP: sample mid-bit; 1 emits a byte strobe, 0 sets load_err. Return to IDLE either way.
// - Loader FSM, advanced by byte strobes only:
//   - LEN_LO -> LEN_HI: 16-bit word count N, little-endian.
//   - WORD: collect DATA_W/8 bytes into a word.
//   - (CSUM if enabled) -> DONE.
// - N=0 or N > 2**ADDR_W: set load_err, go to ERR.
// - Word write: prog_we pulses exactly 1 cycle, 1 cycle after the strobe of the word's last byte.
//   - prog_addr starts at 0 and increments after each write.
//   - The final word is written at address N-1; there is no wrap. N = 2**ADDR_W ends at address all-ones.
// - DONE: load_done=1 and cpu_hold=0 in the same cycle, the cycle after the last write
//   (or after the checksum byte when enabled).
// - DONE and ERR are terminal. Further rx bytes are decoded but ignored: no writes, no flag changes.
//   Only sreset leaves them.
// - ERR: cpu_hold stays 1, load_done stays 0, no further writes.
// - Any framing error during loading sets load_err and enters ERR.
// - sreset mid-byte or mid-image: FSMs return to IDLE/LEN_LO, partial word discarded, cpu_hold=1.
//   Already-written RAM contents are not cleared.
// - Byte strobe and word write never coincide with a new byte strobe: the minimum byte spacing is
//   10*CLKS_PER_BIT.
// CONFIGURATION
// - NANO_LOADER_CHECKSUM_EN defined:
//   - One extra byte follows the last word: the 8-bit two's-complement sum of all preceding image
//     bytes (length bytes included), taken mod 256.
//   - Match enters DONE; mismatch sets load_err and enters ERR. Writes already issued are not revoked.
// - NANO_LOADER_CHECKSUM_EN undefined:
//   - No checksum byte and no CSUM state; DONE follows the last word write.
// TESTING (CLKS_PER_BIT=8, ADDR_W=4, DATA_W=16, 20 ns clock)
// - Reset, rx idle 1000 ns -> cpu_hold=1, load_done=0, load_err=0, prog_we never asserted.
// - Bytes 02 00 34 12 CD AB -> two writes: addr0=0x1234, addr1=0xABCD, each prog_we a single cycle.
//   Then load_done=1 and cpu_hold=0.
// - 4-clock low glitch on rx while idle -> no byte strobe, no error, state unchanged.
// - Bytes 01 00 then a byte with stop bit=0 -> load_err=1, cpu_hold=1, no write.
// - Length 00 00, or length 11 00 (17 > 16) -> load_err=1, no writes.
//   Length 10 00 with 16 words -> last write at addr 0xF, then load_done=1.
// - sreset pulse after 3 of 6 image bytes, then the full image resent -> exactly two writes,
//   at addr0 and addr1, after the resend.
// - With NANO_LOADER_CHECKSUM_EN: 01 00 34 12 B9 -> load_done=1; 01 00 34 12 00 -> load_err=1,
//   cpu_hold=1, one write at addr0=0x1234.

Source files
------------

// File: rtl/nano_uart_loader.sv
// nano_uart_loader: UART 8N1 boot loader that streams a length-prefixed image into program RAM.
// Define NANO_LOADER_CHECKSUM_EN to require a trailing two's-complement checksum byte.
module nano_uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              sreset,
    input  logic              rx,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0] LAST = 8'(DATA_W / 8 - 1);
    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;
    typedef enum logic [2:0] {
        L_LEN_LO, L_LEN_HI, L_WORD, L_WR,
`ifdef NANO_LOADER_CHECKSUM_EN
        L_CSUM,
`endif
        L_DONE, L_ERR
    } lstate_t;
    ustate_t us;
    lstate_t ls;
    logic rx_s1, rx_s2, rx_q, byte_stb, frame_err;
    logic [CW-1:0] cnt;
    logic [2:0] nbit;
    logic [7:0] shreg, len_lo, bcnt;
    logic [15:0] rem;
    logic [DATA_W-1:0] word;
    logic [DATA_W+7:0] cat;
`ifdef NANO_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif
    // Little-endian assembly: each new byte enters at the top and older bytes shift down.
    assign cat = {shreg, word};
    always_ff @(posedge clock) begin
        if (sreset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_q <= 1'b1;
            us <= U_IDLE;
            cnt <= '0;
            nbit <= '0;
            shreg <= '0;
            byte_stb <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_q <= rx_s2;
            byte_stb <= 1'b0;
            frame_err <= 1'b0;
            case (us)
                U_IDLE: begin
                    cnt <= '0;
                    if (rx_q && !rx_s2) us <= U_START;
                end
                U_START:
                    if (cnt == HALF) begin
                        cnt <= '0;
                        nbit <= '0;
                        us <= rx_s2 ? U_IDLE : U_DATA;
                    end else cnt <= cnt + 1'b1;
                U_DATA:
                    if (cnt == FULL) begin
                        cnt <= '0;
                        shreg <= {rx_s2, shreg[7:1]};
                        nbit <= nbit + 1'b1;
                        if (nbit == 3'd7) us <= U_STOP;
                    end else cnt <= cnt + 1'b1;
                U_STOP:
                    if (cnt == FULL) begin
                        cnt <= '0;
                        byte_stb <= rx_s2;
                        frame_err <= !rx_s2;
                        us <= U_IDLE;
                    end else cnt <= cnt + 1'b1;
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (sreset) begin
            ls <= L_LEN_LO;
            prog_we <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            cpu_hold <= 1'b1;
            load_done <= 1'b0;
            load_err <= 1'b0;
            len_lo <= '0;
            rem <= '0;
            word <= '0;
            bcnt <= '0;
        end else begin
            prog_we <= 1'b0;
            if (frame_err && ls != L_DONE && ls != L_ERR) begin
                load_err <= 1'b1;
                ls <= L_ERR;
            end else case (ls)
                L_LEN_LO:
                    if (byte_stb) begin
                        len_lo <= shreg;
                        ls <= L_LEN_HI;
                    end
                L_LEN_HI:
                    if (byte_stb) begin
                        rem <= {shreg, len_lo};
                        bcnt <= '0;
                        if ({shreg, len_lo} == 16'd0 || 32'({shreg, len_lo}) > (32'd1 << ADDR_W)) begin
                            load_err <= 1'b1;
                            ls <= L_ERR;
                        end else ls <= L_WORD;
                    end
                L_WORD:
                    if (byte_stb) begin
                        word <= cat[DATA_W+7:8];
                        bcnt <= (bcnt == LAST) ? 8'd0 : bcnt + 1'b1;
                        if (bcnt == LAST) begin
                            prog_we <= 1'b1;
                            prog_data <= cat[DATA_W+7:8];
                            ls <= L_WR;
                        end
                    end
                L_WR: begin
                    rem <= rem - 1'b1;
                    if (rem == 16'd1) begin
`ifdef NANO_LOADER_CHECKSUM_EN
                        ls <= L_CSUM;
`else
                        ls <= L_DONE;
                        load_done <= 1'b1;
                        cpu_hold <= 1'b0;
`endif
                    end else begin
                        prog_addr <= prog_addr + 1'b1;
                        ls <= L_WORD;
                    end
                end
`ifdef NANO_LOADER_CHECKSUM_EN
                L_CSUM:
                    if (byte_stb) begin
                        if (8'(csum + shreg) == 8'd0) begin
                            ls <= L_DONE;
                            load_done <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            ls <= L_ERR;
                            load_err <= 1'b1;
                        end
                    end
`endif
                default: ;
            endcase
        end
    end
`ifdef NANO_LOADER_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (sreset) csum <= '0;
        else if (byte_stb && (ls == L_LEN_LO || ls == L_LEN_HI || ls == L_WORD)) csum <= csum + shreg;
    end
`endif
endmodule

// File: tb/tb_nano_uart_loader.sv
// tb_nano_uart_loader: directed bench for nano_uart_loader with CLKS_PER_BIT=8, ADDR_W=4, DATA_W=16.
module tb_nano_uart_loader;
    logic clk = 1'b0;
    logic sreset = 1'b1;
    logic rx = 1'b1;
    logic prog_we, cpu_hold, load_done, load_err;
    logic [3:0] prog_addr;
    logic [15:0] prog_data;
    int checks = 0;
    int errors = 0;
    int base = 0;
    int we_long = 0;
    logic prev_we = 1'b0;
    logic [7:0] tsum = '0;
    logic [3:0] wa[$];
    logic [15:0] wd[$];

    nano_uart_loader #(.CLKS_PER_BIT(8), .ADDR_W(4), .DATA_W(16)) dut (
        .clock(clk), .sreset(sreset), .rx(rx), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (prog_we) begin
            wa.push_back(prog_addr);
            wd.push_back(prog_data);
            if (prev_we) we_long++;
        end
        prev_we = prog_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        sreset = 1'b1;
        repeat (3) @(negedge clk);
        sreset = 1'b0;
        tsum = '0;
        base = wa.size();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        tsum = tsum + b;
        @(negedge clk);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (8) @(negedge clk);
        end
        rx = stop;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    task automatic finish_image();
`ifdef NANO_LOADER_CHECKSUM_EN
        send_byte(8'(8'd0 - tsum), 1'b1);
`endif
    endtask

    task automatic check_two_words(input string tag);
        chk({tag, "_nwr"}, wa.size() - base, 2);
        chk({tag, "_a0"}, {28'd0, wa[base]}, 0);
        chk({tag, "_d0"}, {16'd0, wd[base]}, 32'h1234);
        chk({tag, "_a1"}, {28'd0, wa[base+1]}, 1);
        chk({tag, "_d1"}, {16'd0, wd[base+1]}, 32'hABCD);
        chk({tag, "_done"}, {31'd0, load_done}, 1);
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 0);
        chk({tag, "_err"}, {31'd0, load_err}, 0);
    endtask

    initial begin
        do_reset();
        repeat (50) @(negedge clk);
        chk("rst_hold", {31'd0, cpu_hold}, 1);
        chk("rst_done", {31'd0, load_done}, 0);
        chk("rst_err", {31'd0, load_err}, 0);
        chk("rst_addr", {28'd0, prog_addr}, 0);
        chk("rst_data", {16'd0, prog_data}, 0);
        chk("rst_nwr", wa.size(), 0);

        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_err", {31'd0, load_err}, 0);
        chk("glitch_hold", {31'd0, cpu_hold}, 1);
        chk("glitch_nwr", wa.size(), 0);

        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        send_byte(8'hCD, 1'b1); send_byte(8'hAB, 1'b1);
        finish_image();
        check_two_words("img");
        chk("we_single", we_long, 0);

        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b0);
        chk("term_nwr", wa.size() - base, 2);
        chk("term_done", {31'd0, load_done}, 1);
        chk("term_err", {31'd0, load_err}, 0);

        do_reset();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h34, 1'b0);
        chk("frm_err", {31'd0, load_err}, 1);
        chk("frm_hold", {31'd0, cpu_hold}, 1);
        chk("frm_done", {31'd0, load_done}, 0);
        chk("frm_nwr", wa.size() - base, 0);

        do_reset();
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        chk("len0_err", {31'd0, load_err}, 1);
        chk("len0_nwr", wa.size() - base, 0);

        do_reset();
        send_byte(8'h11, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        chk("len17_err", {31'd0, load_err}, 1);
        chk("len17_hold", {31'd0, cpu_hold}, 1);
        chk("len17_nwr", wa.size() - base, 0);

        do_reset();
        send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i + 1), 1'b1);
            send_byte(8'(i + 1), 1'b1);
        end
        finish_image();
        chk("len16_nwr", wa.size() - base, 16);
        chk("len16_a5", {28'd0, wa[base+5]}, 5);
        chk("len16_d5", {16'd0, wd[base+5]}, 32'h0606);
        chk("len16_alast", {28'd0, wa[base+15]}, 32'hF);
        chk("len16_dlast", {16'd0, wd[base+15]}, 32'h1010);
        chk("len16_done", {31'd0, load_done}, 1);
        chk("len16_hold", {31'd0, cpu_hold}, 0);
        chk("len16_err", {31'd0, load_err}, 0);

        do_reset();
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h34, 1'b1);
        do_reset();
        chk("mid_hold", {31'd0, cpu_hold}, 1);
        chk("mid_nwr", wa.size() - base, 0);
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        send_byte(8'hCD, 1'b1); send_byte(8'hAB, 1'b1);
        finish_image();
        check_two_words("resend");

`ifdef NANO_LOADER_CHECKSUM_EN
        do_reset();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'hB9, 1'b1);
        chk("ck_ok_done", {31'd0, load_done}, 1);
        chk("ck_ok_err", {31'd0, load_err}, 0);
        do_reset();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h00, 1'b1);
        chk("ck_bad_err", {31'd0, load_err}, 1);
        chk("ck_bad_hold", {31'd0, cpu_hold}, 1);
        chk("ck_bad_done", {31'd0, load_done}, 0);
        chk("ck_bad_nwr", wa.size() - base, 1);
        chk("ck_bad_a0", {28'd0, wa[base]}, 0);
        chk("ck_bad_d0", {16'd0, wd[base]}, 32'h1234);
`endif
        chk("we_single_end", we_long, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
